// File: rtl/run_monitor.sv
// Execution monitor: counts RUN cycles and retirements, detects END/LOOP/TIMEOUT
// halts, and holds the halt cause and counters stable until clear or reset.
module run_monitor #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         CNT_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] END_ADDR   = 'h500,
  parameter int unsigned         LOOP_LIMIT = 16,
  parameter int unsigned         MAX_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 pc_valid,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 running,
  output logic                 halted,
  output logic                 halt_pulse,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [PC_WIDTH-1:0]  last_pc
);

  localparam int unsigned SAME_W = $clog2(LOOP_LIMIT + 1);
  localparam logic [SAME_W-1:0]    SAME_TRIP = SAME_W'(LOOP_LIMIT - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_TRIP  = CNT_WIDTH'(MAX_CYCLES - 1);

  localparam logic [1:0] CAUSE_END     = 2'b01;
  localparam logic [1:0] CAUSE_LOOP    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state;
  logic              have_prev;
  logic [SAME_W-1:0] same_cnt;

  logic       pc_match;
  logic       end_hit;
  logic       loop_hit;
  logic       tmo_hit;
  logic [1:0] cause_next;

  always_comb begin
    pc_match   = have_prev && (pc == last_pc);
    end_hit    = pc_valid && (pc > END_ADDR);
    loop_hit   = pc_valid && pc_match && (same_cnt == SAME_TRIP);
    tmo_hit    = (cycle_count == CYC_TRIP);
    cause_next = '0;
    if (end_hit)       cause_next = CAUSE_END;
    else if (loop_hit) cause_next = CAUSE_LOOP;
    else if (tmo_hit)  cause_next = CAUSE_TIMEOUT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      running       <= 1'b0;
      halted        <= 1'b0;
      halt_pulse    <= 1'b0;
      halt_cause    <= '0;
      cycle_count   <= '0;
      retired_count <= '0;
      last_pc       <= '0;
      have_prev     <= 1'b0;
      same_cnt      <= '0;
    end else if (clear) begin
      state         <= IDLE;
      running       <= 1'b0;
      halted        <= 1'b0;
      halt_pulse    <= 1'b0;
      halt_cause    <= '0;
      cycle_count   <= '0;
      retired_count <= '0;
      last_pc       <= '0;
      have_prev     <= 1'b0;
      same_cnt      <= '0;
    end else begin
      case (state)
        // IDLE is only reachable through reset/clear, so status is already zero here
        IDLE: begin
          halt_pulse <= 1'b0;
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_WIDTH'(1);
          if (pc_valid) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
            last_pc       <= pc;
            same_cnt      <= pc_match ? same_cnt + SAME_W'(1) : SAME_W'(1);
            have_prev     <= 1'b1;
          end
          // The halting cycle still counts, so the halted instruction is visible
          if (end_hit || loop_hit || tmo_hit) begin
            state      <= HALTED;
            running    <= 1'b0;
            halted     <= 1'b1;
            halt_pulse <= 1'b1;
            halt_cause <= cause_next;
          end
        end
        HALTED: begin
          halt_pulse <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: END, LOOP, TIMEOUT, END-vs-TIMEOUT priority,
// async reset mid-run and clear/restart, using three differently sized instances.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;

  logic        run_a, hlt_a, pls_a;
  logic [1:0]  cau_a;
  logic [31:0] cyc_a, ret_a, lpc_a;
  logic        run_b, hlt_b, pls_b;
  logic [1:0]  cau_b;
  logic [31:0] cyc_b, ret_b, lpc_b;
  logic        run_c, hlt_c, pls_c;
  logic [1:0]  cau_c;
  logic [31:0] cyc_c, ret_c, lpc_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_monitor dut_a (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .pc_valid(pc_valid), .pc(pc),
    .running(run_a), .halted(hlt_a), .halt_pulse(pls_a), .halt_cause(cau_a),
    .cycle_count(cyc_a), .retired_count(ret_a), .last_pc(lpc_a)
  );

  run_monitor #(.MAX_CYCLES(50)) dut_b (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .pc_valid(pc_valid), .pc(pc),
    .running(run_b), .halted(hlt_b), .halt_pulse(pls_b), .halt_cause(cau_b),
    .cycle_count(cyc_b), .retired_count(ret_b), .last_pc(lpc_b)
  );

  run_monitor #(.MAX_CYCLES(10)) dut_c (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .pc_valid(pc_valid), .pc(pc),
    .running(run_c), .halted(hlt_c), .halt_pulse(pls_c), .halt_cause(cau_c),
    .cycle_count(cyc_c), .retired_count(ret_c), .last_pc(lpc_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_running"}, 64'(run_a), 64'd0);
    check({tag, "_halted"},  64'(hlt_a), 64'd0);
    check({tag, "_pulse"},   64'(pls_a), 64'd0);
    check({tag, "_cause"},   64'(cau_a), 64'd0);
    check({tag, "_cycles"},  64'(cyc_a), 64'd0);
    check({tag, "_retired"}, 64'(ret_a), 64'd0);
    check({tag, "_last_pc"}, 64'(lpc_a), 64'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check_idle_a("reset");
    #2 reset = 1'b1;
    tick();
    check_idle_a("post_reset");

    // Linear stream: END halt on 0x504
    start = 1'b1;
    tick();
    check("lin_running", 64'(run_a), 64'd1);
    check("lin_cyc_start", 64'(cyc_a), 64'd0);
    start = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i <= 321; i++) begin
      pc = 32'(i * 4);
      tick();
      if (i == 320) begin
        check("lin_500_no_halt", 64'(hlt_a), 64'd0);
        check("lin_500_running", 64'(run_a), 64'd1);
      end
    end
    check("lin_halted", 64'(hlt_a), 64'd1);
    check("lin_running_low", 64'(run_a), 64'd0);
    check("lin_pulse", 64'(pls_a), 64'd1);
    check("lin_cause", 64'(cau_a), 64'd1);
    check("lin_retired", 64'(ret_a), 64'h142);
    check("lin_cycles", 64'(cyc_a), 64'h142);
    check("lin_last_pc", 64'(lpc_a), 64'h504);
    pc = 32'h508;
    tick();
    check("lin_pulse_once", 64'(pls_a), 64'd0);
    check("lin_frozen_retired", 64'(ret_a), 64'h142);
    check("lin_frozen_last_pc", 64'(lpc_a), 64'h504);
    pc_valid = 1'b0;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("halted_start_ignored", 64'(hlt_a), 64'd1);
    check("halted_start_no_run", 64'(run_a), 64'd0);
    check("halted_start_cycles", 64'(cyc_a), 64'h142);

    // Clear then self-loop run, counted from zero
    do_clear();
    check_idle_a("clear");
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_valid = 1'b1;
    pc = 32'h10;
    tick();
    check("loop_fresh_cycles", 64'(cyc_a), 64'd1);
    check("loop_fresh_retired", 64'(ret_a), 64'd1);
    pc = 32'h14;
    tick();
    pc = 32'h18;
    for (int i = 1; i <= 15; i++) tick();
    check("loop_15_no_halt", 64'(hlt_a), 64'd0);
    tick();
    check("loop_halted", 64'(hlt_a), 64'd1);
    check("loop_pulse", 64'(pls_a), 64'd1);
    check("loop_cause", 64'(cau_a), 64'd2);
    check("loop_retired", 64'(ret_a), 64'd18);
    check("loop_cycles", 64'(cyc_a), 64'd18);
    check("loop_last_pc", 64'(lpc_a), 64'h18);
    pc_valid = 1'b0;
    do_clear();

    // Timeout with MAX_CYCLES=50
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 49; i++) tick();
    check("tmo_49_no_halt", 64'(hlt_b), 64'd0);
    check("tmo_49_cycles", 64'(cyc_b), 64'd49);
    tick();
    check("tmo_halted", 64'(hlt_b), 64'd1);
    check("tmo_pulse", 64'(pls_b), 64'd1);
    check("tmo_cause", 64'(cau_b), 64'd3);
    check("tmo_cycles", 64'(cyc_b), 64'd50);
    check("tmo_retired", 64'(ret_b), 64'd0);
    do_clear();

    // END and TIMEOUT in the same cycle with MAX_CYCLES=10
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    check("sim_9_no_halt", 64'(hlt_c), 64'd0);
    pc_valid = 1'b1;
    pc = 32'h600;
    tick();
    pc_valid = 1'b0;
    check("sim_halted", 64'(hlt_c), 64'd1);
    check("sim_cause_end", 64'(cau_c), 64'd1);
    check("sim_cycles", 64'(cyc_c), 64'd10);
    check("sim_retired", 64'(ret_c), 64'd1);
    check("sim_last_pc", 64'(lpc_c), 64'h600);
    do_clear();

    // Asynchronous reset at RUN cycle 5
    start = 1'b1;
    tick();
    start = 1'b0;
    pc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(32'h100 + i * 4);
      tick();
    end
    check("rst_pre_cycles", 64'(cyc_a), 64'd5);
    #2 reset = 1'b0;
    #1;
    check_idle_a("async_rst");
    tick();
    check("rst_no_pulse", 64'(pls_a), 64'd0);
    check("rst_held_cycles", 64'(cyc_a), 64'd0);
    pc_valid = 1'b0;
    #2 reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_fresh_running", 64'(run_a), 64'd1);
    check("rst_fresh_cycles", 64'(cyc_a), 64'd0);
    check("rst_fresh_retired", 64'(ret_a), 64'd0);
    pc_valid = 1'b1;
    pc = 32'h40;
    tick();
    pc_valid = 1'b0;
    check("rst_run_cycles", 64'(cyc_a), 64'd1);
    check("rst_run_retired", 64'(ret_a), 64'd1);
    check("rst_run_last_pc", 64'(lpc_a), 64'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable execution monitor for the single-cycle and future multi-cycle CPU cores. Replaces ad-hoc bench-side stop checks.
- Watches the retired PC stream and counts cycles and retired instructions.
- Detects three halt conditions: end-address overrun, self-loop (stuck PC), and cycle timeout.
- Latches the halt cause and counters so both benches and on-chip debug logic can read a stable end-of-run status.

Parameters:
PC_WIDTH, 32, width of pc and last_pc
CNT_WIDTH, 32, width of cycle and retire counters
END_ADDR, 32'h00000500, halt when a retired pc is strictly greater than this value
LOOP_LIMIT, 16, number of consecutive identical retired pcs that flags a loop halt (must be >= 2)
MAX_CYCLES, 100000, RUN-state cycle budget (must be >= 1 and < 2^CNT_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a run (sampled only in IDLE)
clear  input  1  synchronous return to IDLE; zeroes all status
pc_valid  input  1  an instruction retires this cycle
pc  input  PC_WIDTH  PC of the retiring instruction
running  output  1  high while in RUN
halted  output  1  high while in HALTED
halt_pulse  output  1  one-cycle strobe on the first HALTED cycle
halt_cause  output  2  00 none, 01 END, 10 LOOP, 11 TIMEOUT
cycle_count  output  CNT_WIDTH  clocks spent in RUN
retired_count  output  CNT_WIDTH  pc_valid cycles seen in RUN
last_pc  output  PC_WIDTH  most recent retired pc

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output 0. Internal same-PC counter and have_prev flag cleared. Reset mid-RUN aborts the run immediately with no halt_pulse.
- FSM states: IDLE, RUN, HALTED. All registers are updated on the rising clk edge.
- clear=1 has top priority in every state:
  - next state is IDLE;
  - all outputs and internal state are zeroed on that edge.
- IDLE:
  - start=1 moves to RUN on the next edge.
  - Counters, have_prev, same_cnt, halt_cause and last_pc are zeroed on entry.
  - pc_valid is ignored.
- RUN, each cycle:
  - cycle_count += 1.
  - If pc_valid:
    - retired_count += 1; last_pc <= pc.
    - If have_prev and pc == last_pc, then same_cnt += 1; otherwise same_cnt <= 1.
    - have_prev <= 1.
- Halt terms are evaluated combinationally from the current-cycle inputs and registers:
  - end_hit = pc_valid && (pc > END_ADDR), unsigned compare.
  - loop_hit = pc_valid && have_prev && (pc == last_pc) && (same_cnt == LOOP_LIMIT-1). This means the LOOP_LIMIT-th identical retirement triggers it.
  - tmo_hit = (cycle_count == MAX_CYCLES-1). This means the MAX_CYCLES-th RUN cycle triggers it.
- Priority when terms coincide: END > LOOP > TIMEOUT. halt_cause records only the winner.
- The cycle in which a halt is detected still performs all of its RUN-cycle updates. The halted instruction is therefore counted and appears in last_pc.
  - On that edge: state=HALTED, halt_cause latched, halt_pulse=1 for exactly one cycle.
- HALTED:
  - All status outputs are frozen.
  - start and pc_valid are ignored.
  - The block leaves HALTED only via clear or reset.
- Counters never wrap. MAX_CYCLES < 2^CNT_WIDTH guarantees that cycle_count halts before overflow. retired_count <= cycle_count always holds.
- running = (state==RUN); halted = (state==HALTED). Both are registered outputs, never high together.

Test Plan:
- Linear stream: start, then pc=0,4,8,… one per cycle with END_ADDR=0x500. Required response:
  - halt on pc=0x504 with halt_cause=01;
  - retired_count=0x142, cycle_count=0x142, last_pc=0x504;
  - halt_pulse high for exactly one cycle.
- Self-loop: pc=0x10,0x14, then pc=0x18 repeated, LOOP_LIMIT=16. Required response: halt on the 16th 0x18 retirement; halt_cause=10; retired_count=18.
- Timeout: MAX_CYCLES=50, pc_valid=0 throughout. Required response: halt after the 50th RUN cycle; cycle_count=50, retired_count=0, halt_cause=11.
- Simultaneous: MAX_CYCLES=10, retire pc=0x600 on the 10th RUN cycle. Required response: halt_cause=01 (END wins).
- Asynchronous reset mid-run: assert reset=0 between clock edges at cycle 5 of RUN. Required response:
  - all outputs read 0 before the next edge;
  - no halt_pulse;
  - after release, start begins a fresh run with counters at 0.
- Clear/restart: from HALTED, clear=1 for one cycle, then start=1. Required response: IDLE with zeroed status, then RUN with a new run counted from 0. start asserted in HALTED without clear has no effect.
